// File: rtl/modexp_seq.sv
// Host-side sequencer for a modexp engine: streams E, N, R, T, NPRIME0, M into the engine and returns result words.
// Optional COMPUTE watchdog is enabled by defining MODEXP_SEQ_TIMEOUT_EN (then TIMEOUT bounds the wait).
module modexp_seq #(
    parameter int WORD_W     = 128,
    parameter int NWORDS     = 32,
    parameter int NP_W       = 64,
    parameter int ST_COMPUTE = 13,
    parameter int ST_DONE    = 15
`ifdef MODEXP_SEQ_TIMEOUT_EN
    , parameter int TIMEOUT  = 2**20
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mx_reset,
    output logic [WORD_W-1:0] e_buf,
    output logic [WORD_W-1:0] n_buf,
    output logic [WORD_W-1:0] r_buf,
    output logic [WORD_W-1:0] t_buf,
    output logic [WORD_W-1:0] m_buf,
    output logic [NP_W-1:0]   nprime0_buf,
    output logic              startInput,
    output logic              read,
    output logic              loadNext,
    output logic              startCompute,
    output logic              getResult,
    input  logic [4:0]        exp_state,
    input  logic [WORD_W-1:0] res_out,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int               CNT_W     = $clog2(NWORDS + 1);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NWORDS - 1);
    localparam logic [CNT_W-1:0] ALL_WORDS = CNT_W'(NWORDS);
    localparam logic [4:0]       ST_C      = 5'(ST_COMPUTE);
    localparam logic [4:0]       ST_D      = 5'(ST_DONE);

    typedef enum logic [3:0] {
        IDLE, MXRST, LD_E, LD_N, LD_R, LD_T, LD_NP, LD_M, COMPUTE, RESULT, ERR
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             beat, capture, finish, fault, clear_err, tmo_hit;

    function automatic state_t load_succ(input state_t s);
        case (s)
            LD_E:    return LD_N;
            LD_N:    return LD_R;
            LD_R:    return LD_T;
            LD_T:    return LD_NP;
            LD_M:    return COMPUTE;
            default: return IDLE;
        endcase
    endfunction

`ifdef MODEXP_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] tmo_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            tmo_reg <= '0;
        else if (state_reg == COMPUTE)
            tmo_reg <= tmo_reg + 1'b1;
        else
            tmo_reg <= '0;
    end

    assign tmo_hit = (tmo_reg == TO_W'(TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        mx_reset     = 1'b0;
        in_ready     = 1'b0;
        read         = 1'b0;
        startInput   = 1'b0;
        startCompute = 1'b0;
        getResult    = 1'b0;
        capture      = 1'b0;
        finish       = 1'b0;
        fault        = 1'b0;
        clear_err    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (go) begin
                    state_next = MXRST;
                    cnt_next   = '0;
                    clear_err  = 1'b1;
                end
            end
            MXRST: begin
                // cnt_reg doubles as the 2-cycle engine reset timer
                mx_reset = 1'b1;
                if (cnt_reg == CNT_W'(1)) begin
                    cnt_next   = '0;
                    state_next = LD_E;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            LD_E, LD_N, LD_R, LD_T, LD_M: begin
                startInput = 1'b1;
                in_ready   = 1'b1;
                read       = 1'b1;
                if (in_valid) begin
                    if (cnt_reg == LAST_WORD) begin
                        cnt_next   = '0;
                        state_next = load_succ(state_reg);
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            LD_NP: begin
                startInput = 1'b1;
                in_ready   = 1'b1;
                read       = 1'b1;
                if (in_valid)
                    state_next = LD_M;
            end
            COMPUTE: begin
                startCompute = 1'b1;
                if (exp_state == ST_C) begin
                    state_next = RESULT;
                    cnt_next   = '0;
                end else if (tmo_hit) begin
                    fault      = 1'b1;
                    state_next = ERR;
                end
            end
            RESULT: begin
                getResult = 1'b1;
                if (exp_state == ST_D) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (exp_state > ST_C && exp_state < ST_D) begin
                    // an extra word beyond NWORDS is flagged, not forwarded to the host
                    if (cnt_reg == ALL_WORDS) begin
                        fault      = 1'b1;
                        state_next = ERR;
                        cnt_next   = '0;
                    end else begin
                        capture  = 1'b1;
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            ERR: begin
                mx_reset   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        beat = in_ready & in_valid;
        busy = (state_reg != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_buf       <= '0;
            n_buf       <= '0;
            r_buf       <= '0;
            t_buf       <= '0;
            m_buf       <= '0;
            nprime0_buf <= '0;
            loadNext    <= 1'b0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            loadNext  <= beat;
            out_valid <= capture;
            done      <= finish;
            if (capture)
                out_data <= res_out;
            if (fault)
                error <= 1'b1;
            else if (clear_err)
                error <= 1'b0;
            if (beat) begin
                case (state_reg)
                    LD_E:    e_buf       <= in_data;
                    LD_N:    n_buf       <= in_data;
                    LD_R:    r_buf       <= in_data;
                    LD_T:    t_buf       <= in_data;
                    LD_NP:   nprime0_buf <= in_data[NP_W-1:0];
                    LD_M:    m_buf       <= in_data;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_modexp_seq.sv
// Scoreboard bench for modexp_seq: directed operand streams, a scripted engine model, queue-based result checking.
module tb_modexp_seq;

    localparam int          WORD_W = 128;
    localparam int          NWORDS = 32;
    localparam int          NP_W   = 64;
    localparam logic [63:0] NP0    = 64'h3bea2df6a3b18a91;

    logic              clk = 1'b0;
    logic              reset, go, in_valid, in_ready, mx_reset;
    logic [WORD_W-1:0] in_data, e_buf, n_buf, r_buf, t_buf, m_buf, res_out, out_data;
    logic [NP_W-1:0]   nprime0_buf;
    logic              startInput, read, loadNext, startCompute, getResult;
    logic [4:0]        exp_state;
    logic              out_valid, busy, done, error;

    int n_cmp = 0, n_bad = 0;
    int ln_cnt = 0, sc_cnt = 0, mx_cnt = 0, done_cnt = 0, ov_cnt = 0;
    logic [WORD_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    modexp_seq #(
        .WORD_W(WORD_W), .NWORDS(NWORDS), .NP_W(NP_W), .ST_COMPUTE(13), .ST_DONE(15)
`ifdef MODEXP_SEQ_TIMEOUT_EN
        , .TIMEOUT(100)
`endif
    ) dut (
        .clk(clk), .reset(reset), .go(go),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mx_reset(mx_reset),
        .e_buf(e_buf), .n_buf(n_buf), .r_buf(r_buf), .t_buf(t_buf), .m_buf(m_buf),
        .nprime0_buf(nprime0_buf),
        .startInput(startInput), .read(read), .loadNext(loadNext),
        .startCompute(startCompute), .getResult(getResult),
        .exp_state(exp_state), .res_out(res_out),
        .out_data(out_data), .out_valid(out_valid),
        .busy(busy), .done(done), .error(error)
    );

    task automatic chk_bit(input string name, input logic act, input logic expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", name, act, expv);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic chk_word(input string name, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // monitor: event counters plus scoreboard pop on every result word
    always @(negedge clk) begin
        logic [WORD_W-1:0] expw;
        if (loadNext)     ln_cnt++;
        if (startCompute) sc_cnt++;
        if (mx_reset)     mx_cnt++;
        if (done)         done_cnt++;
        if (out_valid) begin
            ov_cnt++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL out_word: got unexpected word %h, expected none", out_data);
            end else begin
                expw = exp_q.pop_front();
                if (out_data !== expw) begin
                    n_bad++;
                    $display("FAIL out_word: got %h, expected %h", out_data, expw);
                end else begin
                    $display("result word %0d = %h ok", ov_cnt - 1, out_data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [WORD_W-1:0] opw(input int op, input int i);
        logic [7:0]  o;
        logic [31:0] ix;
        o  = op[7:0];
        ix = i;
        if (op == 0) return (i == 0) ? WORD_W'(5) : '0;
        return {o, 88'h0, ix};
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_go();
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic send(input logic [WORD_W-1:0] d);
        int k;
        k = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && k < 100) begin
            tick();
            k++;
        end
        if (!in_ready) chk_bit("in_ready_wait", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic load_operand(input int op, input int nw, input bit gap);
        int snap_ln;
        logic [WORD_W-1:0] snap_r;
        for (int i = 0; i < nw; i++) begin
            send(opw(op, i));
            if (op == 0 && i == 0) chk_word("e_buf_word0", e_buf, WORD_W'(5));
            if (gap && i == 5) begin
                tick();
                snap_ln = ln_cnt;
                snap_r  = r_buf;
                tick(6);
                chk_int("gap_no_loadNext", ln_cnt, snap_ln);
                chk_word("gap_r_buf_hold", r_buf, snap_r);
                chk_word("gap_r_buf_val", r_buf, opw(2, 5));
            end
        end
    endtask

    task automatic load_all(input bit gap);
        load_operand(0, NWORDS, 1'b0);
        load_operand(1, NWORDS, 1'b0);
        load_operand(2, NWORDS, gap);
        load_operand(3, NWORDS, 1'b0);
        send({64'hdeadbeef0badf00d, NP0});
        load_operand(4, NWORDS, 1'b0);
    endtask

    task automatic run_result(input int nw);
        exp_state = 5'd13;
        tick();
        chk_bit("getResult_after_13", getResult, 1'b1);
        chk_bit("startCompute_off", startCompute, 1'b0);
        for (int i = 0; i < nw; i++) begin
            exp_state = 5'd14;
            res_out   = opw(9, i) ^ {96'h0, 32'h5a5a0000};
            if (i < NWORDS) exp_q.push_back(res_out);
            tick();
        end
        if (nw <= NWORDS) begin
            exp_state = 5'd15;
            tick();
            chk_bit("done_pulse", done, 1'b1);
            chk_bit("idle_after_done", busy, 1'b0);
        end
        exp_state = 5'd0;
    endtask

    initial begin
        reset = 1'b0; go = 1'b0; in_valid = 1'b0; in_data = '0;
        exp_state = 5'd0; res_out = '0;
        tick(3);
        chk_bit("rst_busy", busy, 1'b0);
        chk_bit("rst_in_ready", in_ready, 1'b0);
        chk_bit("rst_mx_reset", mx_reset, 1'b0);
        chk_bit("rst_out_valid", out_valid, 1'b0);
        chk_bit("rst_error", error, 1'b0);
        reset = 1'b1;
        tick(2);

        // reset mid-LD_N, with go latency checked on the way
        pulse_go();
        chk_bit("mxrst_c1", mx_reset, 1'b1);
        tick();
        chk_bit("mxrst_c2", mx_reset, 1'b1);
        chk_bit("mxrst_no_ready", in_ready, 1'b0);
        tick();
        chk_bit("latency_in_ready", in_ready, 1'b1);
        chk_bit("ld_e_mx_reset_off", mx_reset, 1'b0);
        chk_bit("ld_e_startInput", startInput, 1'b1);
        load_operand(0, NWORDS, 1'b0);
        load_operand(1, 10, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk_bit("midrst_busy", busy, 1'b0);
        chk_bit("midrst_in_ready", in_ready, 1'b0);
        chk_bit("midrst_startInput", startInput, 1'b0);
        chk_bit("midrst_loadNext", loadNext, 1'b0);
        chk_word("midrst_n_buf", n_buf, '0);
        @(posedge clk);
        #1 reset = 1'b1;
        tick(2);
        chk_bit("postrst_in_ready", in_ready, 1'b0);
        chk_bit("postrst_busy", busy, 1'b0);
        $display("reset-mid-load transaction done");

        // full load with a host stall in LD_R; go coincides with exp_state==13 in IDLE
        ln_cnt = 0;
        exp_state = 5'd13;
        pulse_go();
        exp_state = 5'd0;
        chk_bit("go_wins_mx_reset", mx_reset, 1'b1);
        load_all(1'b1);
        tick();
        chk_int("loadNext_count", ln_cnt, 5 * NWORDS + 1);
        chk_word("nprime0_buf", {64'h0, nprime0_buf}, {64'h0, NP0});
        chk_word("n_buf_last", n_buf, opw(1, NWORDS - 1));
        chk_word("r_buf_last", r_buf, opw(2, NWORDS - 1));
        chk_word("t_buf_last", t_buf, opw(3, NWORDS - 1));
        chk_word("m_buf_last", m_buf, opw(4, NWORDS - 1));
        chk_bit("compute_startCompute", startCompute, 1'b1);
        chk_bit("compute_in_ready", in_ready, 1'b0);
        chk_bit("compute_read", read, 1'b0);
        $display("load transaction done, loadNext pulses=%0d", ln_cnt);

        // result phase: 32 words then DONE
        tick(5);
        chk_bit("compute_waits", startCompute, 1'b1);
        ov_cnt = 0; done_cnt = 0;
        run_result(NWORDS);
        tick();
        chk_bit("done_one_cycle", done, 1'b0);
        tick(2);
        chk_int("done_count", done_cnt, 1);
        chk_int("out_valid_count", ov_cnt, NWORDS);
        chk_int("queue_drained", exp_q.size(), 0);
        chk_bit("no_error", error, 1'b0);
        $display("result transaction done, words=%0d", ov_cnt);

`ifdef MODEXP_SEQ_TIMEOUT_EN
        // watchdog: engine never reports compute finished
        pulse_go();
        load_all(1'b0);
        sc_cnt = 0;
        for (int k = 0; k < 300 && !error; k++) tick();
        chk_bit("timeout_error", error, 1'b1);
        chk_int("timeout_cycles", sc_cnt, 100);
        chk_bit("timeout_err_mx_reset", mx_reset, 1'b1);
        tick();
        chk_bit("timeout_mx_reset_off", mx_reset, 1'b0);
        chk_bit("timeout_idle", busy, 1'b0);
        $display("timeout transaction done");
`endif

        // go while busy is ignored; 33 result words trigger the error path
        mx_cnt = 0; ov_cnt = 0;
        pulse_go();
        chk_bit("go_clears_error", error, 1'b0);
        pulse_go();
        load_all(1'b0);
        tick();
        chk_int("mx_reset_cycles", mx_cnt, 2);
        run_result(NWORDS + 1);
        chk_bit("overrun_error", error, 1'b1);
        chk_bit("overrun_err_mx_reset", mx_reset, 1'b1);
        tick();
        chk_bit("overrun_mx_reset_off", mx_reset, 1'b0);
        chk_bit("overrun_idle", busy, 1'b0);
        chk_bit("error_sticky", error, 1'b1);
        chk_int("overrun_mx_total", mx_cnt, 3);
        chk_int("overrun_words", ov_cnt, NWORDS);
        chk_int("overrun_queue", exp_q.size(), 0);
        chk_int("overrun_no_done", done_cnt, 1);
        $display("overrun transaction done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
